ps2_host_tx: RTL

- Host-to-device PS/2 transmitter; the sending counterpart to the ps2_scan keyboard receiver.
- Sends command bytes to the keyboard, e.g. ED set-LEDs, F4 enable, FF reset.
- Drives the shared open-drain ps2_clk/ps2_data lines through active-high pull-low enables; ps2_scan keeps listening to the same pins.
- Sits between the game control logic and the pad buffers.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_sync.sv | 45 ++++
 rtl/ps2_host_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 host transmitter states, command/response codes and odd-parity helper
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE,
    ST_DONE,
    ST_ERR
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;

  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - pad synchronizer with run-length level filter and falling-edge pulse
// FILTER_LEN=1 gives a plain 2-FF sync whose edge pulse lands 3 cycles after the pad edge.
module ps2_line_sync #(
  parameter int FILTER_LEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  output logic level_o,
  output logic fe_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          s1_q, s2_q, lvl_q, fe_q;
  logic [CW-1:0] run_q;

  // Idle PS/2 lines float high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      lvl_q <= 1'b1;
      fe_q  <= 1'b0;
      run_q <= '0;
    end else begin
      s1_q <= pad_i;
      s2_q <= s1_q;
      fe_q <= 1'b0;
      if (s2_q == lvl_q) begin
        run_q <= '0;
      end else if (run_q == CW'(FILTER_LEN - 1)) begin
        lvl_q <= s2_q;
        fe_q  <= lvl_q;
        run_q <= '0;
      end else begin
        run_q <= run_q + CW'(1);
      end
    end
  end

  assign level_o = lvl_q;
  assign fe_o    = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter driving open-drain pull-low enables
// Define PS2_CLK_FILTER_EN to deglitch the sampled ps2_clk over FILTER_LEN cycles.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_CLK_FILTER_EN
  localparam bit CLK_FILTER_EN = 1'b1;
`else
  localparam bit CLK_FILTER_EN = 1'b0;
`endif

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    frame_q, frame_d;
  logic          clk_lvl, clk_fe, data_lvl, data_fe_unused;

  ps2_line_sync #(.FILTER_LEN(CLK_FILTER_EN ? FILTER_LEN : 1)) u_clk_sync (
    .clk(clk), .rst(rst), .pad_i(ps2_clk_in), .level_o(clk_lvl), .fe_o(clk_fe)
  );

  ps2_line_sync #(.FILTER_LEN(1)) u_data_sync (
    .clk(clk), .rst(rst), .pad_i(ps2_data_in), .level_o(data_lvl), .fe_o(data_fe_unused)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    tx_ready    = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          frame_d = {1'b1, ps2_odd_parity(tx_data), tx_data};
          cnt_d   = '0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == INH_LAST) begin
          ps2_data_oe = 1'b1;
          cnt_d       = '0;
          bit_d       = '0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ, ST_SHIFT, ST_ACK, ST_RELEASE: begin
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        if (state_q == ST_REQ) ps2_data_oe = 1'b1;
        else if (state_q == ST_SHIFT) ps2_data_oe = ~frame_q[0];
        // A timeout outranks a clock edge arriving in the same cycle.
        if (cnt_q >= TMO_LAST) begin
          state_d = ST_ERR;
        end else begin
          case (state_q)
            ST_REQ: if (clk_fe) begin
              bit_d   = bit_q + 4'd1;
              state_d = ST_SHIFT;
            end
            ST_SHIFT: if (clk_fe) begin
              bit_d = bit_q + 4'd1;
              if (bit_q == 4'd9) state_d = ST_ACK;
              else frame_d = {1'b1, frame_q[8:1]};
            end
            ST_ACK: if (clk_fe) state_d = data_lvl ? ST_ERR : ST_RELEASE;
            default: if (clk_lvl && data_lvl) state_d = ST_DONE;
          endcase
        end
      end
      ST_DONE: begin
        tx_done = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        tx_err  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
    end
  end

endmodule
